i2s_rx: RTL
===========

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001: Parameter SAMPLE_WIDTH, default 16, sets the number of bits captured per channel.
REQ-002: Parameter BIT_DELAY, default 1, sets the number of bit slots after an LRCK change that are discarded before the sample MSB (I2S = 1).
REQ-003: clk  input  1  sampling clock; shall be at least 4x audio_bclk (nominally 12.288 MHz with audio_bclk = clk/4).
REQ-004: reset_n  input  1  asynchronous active-low reset.
REQ-005: audio_bclk  input  1  serial bit clock, asynchronous to clk.
REQ-006: audio_lrck  input  1  word select; 0 = left, 1 = right.
REQ-007: audio_dac  input  1  serial data, MSB first, changed by the transmitter on the falling edge of audio_bclk.
REQ-008: out_left  output  SAMPLE_WIDTH  last complete left sample, two's complement.
REQ-009: out_right  output  SAMPLE_WIDTH  last complete right sample, two's complement.
REQ-010: out_valid  output  1  a stereo pair is held on out_left/out_right.
REQ-011: out_ready  input  1  consumer accepts the pair.
REQ-012: overrun  output  1  sticky; an unaccepted pair was overwritten.
REQ-013: short_frame  output  1  sticky; a half-frame ended before its sample completed.
REQ-014: error_clear  input  1  clears both sticky flags.

Function
REQ-015: audio_bclk, audio_lrck and audio_dac shall each pass through a 2-flop synchronizer; a bit event is a 0->1 transition of synchronized bclk, detected with one further register.
REQ-016: All capture logic shall act only on bit events, sampling synchronized lrck and dac at that event.
REQ-017: States: SYNC_WAIT, LEFT, RIGHT; reset enters SYNC_WAIT.
REQ-018: SYNC_WAIT: no capture; an lrck value differing from the value at the previous bit event moves to LEFT (new lrck = 0) or RIGHT (new lrck = 1).
REQ-019: LEFT/RIGHT: a bit counter (6 bits, saturating at 63) shall clear to 0 on the lrck-change event and increment on every other bit event.
REQ-020: Slots 0..BIT_DELAY-1 shall be discarded; slots BIT_DELAY..BIT_DELAY+SAMPLE_WIDTH-1 shall shift MSB-first into the shift register; later slots shall be ignored.
REQ-021: On an lrck 0->1 event in LEFT: if all SAMPLE_WIDTH bits were captured, the shift register shall load a pending-left register; otherwise short_frame shall set and pending-left shall be marked invalid. The state then moves to RIGHT.
REQ-022: On an lrck 1->0 event in RIGHT: if the right half is complete and pending-left is valid, {pending-left, shift register} shall load out_left/out_right and out_valid shall be 1 from the next clk cycle. An incomplete right half shall set short_frame and load nothing. The state then moves to LEFT.
REQ-023: Handshake: the pair is transferred in a cycle with out_valid=1 and out_ready=1; out_valid falls the next cycle unless a new pair loads in the same cycle, in which case out_valid stays 1 with the new data.
REQ-024: A new pair loading while out_valid=1 and out_ready=0 shall overwrite the outputs and set overrun.
REQ-025: error_clear shall clear overrun/short_frame the next cycle; an error set in the same cycle shall take priority (flag stays 1).
REQ-026: Outputs shall change only as specified above; out_left/out_right shall hold their values while out_valid=0.

Reset
REQ-027: Asserting reset_n low, at any time including mid-frame, shall immediately force out_left=0, out_right=0, out_valid=0, overrun=0, short_frame=0, synchronizers=0, counter=0, pending-left invalid, state SYNC_WAIT.
REQ-028: After release, the first partial half-frame shall not produce output; the first pair shall be emitted at the end of the first complete left+right frame.

Verification
REQ-029: Reset, then I2S frames at bclk=clk/4 (32 slots/half, 1-bit delay), L=16'h1234, R=16'hABCD, out_ready=1 -> first partial frame dropped; each later frame gives out_left=1234, out_right=ABCD, a one-cycle out_valid, overrun=0.
REQ-030: out_ready=0 for two frames, L=16'h0001 then 16'h0002 -> out_valid stays 1, overrun=1, out_left=0002.
REQ-031: A left half with lrck toggling after 10 slots -> short_frame=1, no out_valid for that frame, out_left keeps the previous value; the next clean frame outputs normally.
REQ-032: reset_n pulsed low mid right-half -> all outputs 0 asynchronously; output resumes only after a full subsequent frame.
REQ-033: L=16'h8000, R=16'h7FFF with 16 trailing nonzero slots -> out_left=8000, out_right=7FFF (trailing bits ignored).
REQ-034: error_clear asserted in the same cycle as a new short_frame event -> short_frame remains 1; error_clear alone the following cycle -> 0.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrck/data on clk, assembles left/right samples
// and presents each complete stereo pair through a valid/ready handshake.
module i2s_rx #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned BIT_DELAY    = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    audio_bclk,
   input  logic                    audio_lrck,
   input  logic                    audio_dac,
   output logic [SAMPLE_WIDTH-1:0] out_left,
   output logic [SAMPLE_WIDTH-1:0] out_right,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun,
   output logic                    short_frame,
   input  logic                    error_clear
);

   localparam int unsigned      CNT_W      = 6;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] FIRST_SLOT = CNT_W'(BIT_DELAY);
   localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(BIT_DELAY + SAMPLE_WIDTH - 1);

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      LEFT      = 2'd1,
      RIGHT     = 2'd2
   } state_t;

   state_t                  state;
   logic [1:0]              bclk_sync;
   logic [1:0]              lrck_sync;
   logic [1:0]              dac_sync;
   logic                    bclk_d;
   logic                    lrck_prev;
   logic                    lrck_seen;
   logic [CNT_W-1:0]        bit_cnt;
   logic [SAMPLE_WIDTH-1:0] shift_reg;
   logic [SAMPLE_WIDTH-1:0] pend_left;
   logic                    pend_valid;

   logic                    bit_event_c;
   logic                    lrck_c;
   logic                    dac_c;
   logic                    lrck_chg_c;
   logic                    half_done_c;
   logic                    in_window_c;
   logic [CNT_W-1:0]        cnt_inc_c;
   logic [SAMPLE_WIDTH-1:0] slot0_sr_c;

   // Bit event = rising edge of the synchronized bit clock
   assign bit_event_c = bclk_sync[1] & ~bclk_d;
   assign lrck_c      = lrck_sync[1];
   assign dac_c       = dac_sync[1];
   // lrck_seen suppresses a false boundary on the very first event after reset
   assign lrck_chg_c  = lrck_seen && (lrck_c != lrck_prev);
   assign half_done_c = (bit_cnt >= LAST_SLOT);
   assign cnt_inc_c   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
   assign in_window_c = (cnt_inc_c >= FIRST_SLOT) && (cnt_inc_c <= LAST_SLOT);
   // With zero bit delay the boundary slot already carries the MSB
   assign slot0_sr_c  = (BIT_DELAY == 0) ? SAMPLE_WIDTH'(dac_c) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= SYNC_WAIT;
         bclk_sync   <= '0;
         lrck_sync   <= '0;
         dac_sync    <= '0;
         bclk_d      <= 1'b0;
         lrck_prev   <= 1'b0;
         lrck_seen   <= 1'b0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         pend_left   <= '0;
         pend_valid  <= 1'b0;
         out_left    <= '0;
         out_right   <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], audio_bclk};
         lrck_sync <= {lrck_sync[0], audio_lrck};
         dac_sync  <= {dac_sync[0], audio_dac};
         bclk_d    <= bclk_sync[1];

         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         // Later assignments below (error set, new pair) take priority
         if (error_clear) begin
            overrun     <= 1'b0;
            short_frame <= 1'b0;
         end

         if (bit_event_c) begin
            lrck_prev <= lrck_c;
            lrck_seen <= 1'b1;
            case (state)
               SYNC_WAIT: begin
                  if (lrck_chg_c) begin
                     state     <= lrck_c ? RIGHT : LEFT;
                     bit_cnt   <= '0;
                     shift_reg <= slot0_sr_c;
                  end
               end
               LEFT, RIGHT: begin
                  if (lrck_chg_c) begin
                     bit_cnt   <= '0;
                     shift_reg <= slot0_sr_c;
                     if (state == LEFT) begin
                        if (half_done_c) begin
                           pend_left  <= shift_reg;
                           pend_valid <= 1'b1;
                        end else begin
                           short_frame <= 1'b1;
                           pend_valid  <= 1'b0;
                        end
                        state <= RIGHT;
                     end else begin
                        if (!half_done_c) begin
                           short_frame <= 1'b1;
                        end else if (pend_valid) begin
                           out_left  <= pend_left;
                           out_right <= shift_reg;
                           out_valid <= 1'b1;
                           if (out_valid && !out_ready) begin
                              overrun <= 1'b1;
                           end
                        end
                        pend_valid <= 1'b0;
                        state      <= LEFT;
                     end
                  end else begin
                     bit_cnt <= cnt_inc_c;
                     if (in_window_c) begin
                        shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], dac_c};
                     end
                  end
               end
               default: state <= SYNC_WAIT;
            endcase
         end
      end
   end

endmodule
